// File: rtl/wb4_to_pi1.sv
// Wishbone B4 pipelined slave to single-master PI1 initiator bridge.
// One transaction in flight; PI1 request and Wishbone response are registered.
module wb4_to_pi1 #(
   parameter  int unsigned ARCHBITSZ = 32,
   localparam int unsigned SELBITSZ  = ARCHBITSZ / 8,
   localparam int unsigned LSBITSZ   = $clog2(SELBITSZ),
   localparam int unsigned ADDRBITSZ = ARCHBITSZ - LSBITSZ
) (
   input  logic                 wb4_clk_i,
   input  logic                 wb4_rst_ni,
   input  logic                 wb4_cyc_i,
   input  logic                 wb4_stb_i,
   input  logic                 wb4_we_i,
   input  logic [ARCHBITSZ-1:0] wb4_addr_i,
   input  logic [ARCHBITSZ-1:0] wb4_data_i,
   input  logic [SELBITSZ-1:0]  wb4_sel_i,
   output logic                 wb4_stall_o,
   output logic                 wb4_ack_o,
   output logic [ARCHBITSZ-1:0] wb4_data_o,
   output logic [1:0]           pi1_op_o,
   output logic [ADDRBITSZ-1:0] pi1_addr_o,
   output logic [ARCHBITSZ-1:0] pi1_data_o,
   input  logic [ARCHBITSZ-1:0] pi1_data_i,
   output logic [SELBITSZ-1:0]  pi1_sel_o,
   input  logic                 pi1_rdy_i
);

   if (ARCHBITSZ != 16 && ARCHBITSZ != 32 && ARCHBITSZ != 64 &&
       ARCHBITSZ != 128 && ARCHBITSZ != 256) begin : g_bad_width
      $error("wb4_to_pi1: unsupported ARCHBITSZ");
   end

   localparam logic [1:0] OP_NOOP = 2'b00;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_RD   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Latched request payload, driven onto PI1 while the op is pending.
   typedef struct packed {
      logic                 we;
      logic [ADDRBITSZ-1:0] addr;
      logic [ARCHBITSZ-1:0] data;
      logic [SELBITSZ-1:0]  sel;
   } req_t;

   state_t               state_q, state_d;
   logic [1:0]           op_q, op_d;
   req_t                 req_q, req_d;
   logic                 aborted_q, aborted_d;
   logic                 ack_q, ack_d;
   logic [ARCHBITSZ-1:0] rdata_q, rdata_d;
   logic                 wb_req_c;
   logic                 unused_addr_lsb;

   assign wb_req_c        = wb4_cyc_i & wb4_stb_i;
   assign unused_addr_lsb = ^wb4_addr_i[LSBITSZ-1:0];

   // State and registered outputs.
   always_ff @(posedge wb4_clk_i or negedge wb4_rst_ni) begin
      if (!wb4_rst_ni) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_NOOP;
         req_q     <= '0;
         aborted_q <= 1'b0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         req_q     <= req_d;
         aborted_q <= aborted_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
      end
   end

   // Next state, next PI1 request and next Wishbone response.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      req_d     = req_q;
      aborted_d = aborted_q;
      ack_d     = 1'b0;
      rdata_d   = rdata_q;

      case (state_q)
         ST_IDLE: begin
            op_d      = OP_NOOP;
            aborted_d = 1'b0;
            if (wb_req_c) begin
               if (wb4_we_i && (wb4_sel_i == '0)) begin
                  // Write with no byte lanes: nothing to send, complete locally.
                  ack_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  req_d.we   = wb4_we_i;
                  req_d.addr = wb4_addr_i[ARCHBITSZ-1:LSBITSZ];
                  req_d.data = wb4_data_i;
                  req_d.sel  = wb4_sel_i;
                  op_d       = wb4_we_i ? OP_WR : OP_RD;
                  state_d    = ST_REQ;
               end
            end
         end

         ST_REQ: begin
            if (pi1_rdy_i) begin
               // Op consumed; a simultaneous cyc drop still owes a drained response.
               op_d      = OP_NOOP;
               aborted_d = ~wb4_cyc_i;
               state_d   = ST_RESP;
            end else if (!wb4_cyc_i) begin
               op_d    = OP_NOOP;
               state_d = ST_IDLE;
            end
         end

         ST_RESP: begin
            if (!wb4_cyc_i) begin
               aborted_d = 1'b1;
            end
            if (pi1_rdy_i) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b0;
               if (!aborted_q && wb4_cyc_i) begin
                  ack_d   = 1'b1;
                  rdata_d = req_q.we ? '0 : pi1_data_i;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            op_d    = OP_NOOP;
         end
      endcase
   end

   assign wb4_stall_o = (state_q != ST_IDLE);
   assign wb4_ack_o   = ack_q;
   assign wb4_data_o  = rdata_q;
   assign pi1_op_o    = op_q;
   assign pi1_addr_o  = req_q.addr;
   assign pi1_data_o  = req_q.data;
   assign pi1_sel_o   = req_q.sel;

endmodule

// File: tb/tb_wb4_to_pi1.sv
// Bench for wb4_to_pi1: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_wb4_to_pi1;
   localparam int unsigned W  = 32;
   localparam int unsigned SW = W / 8;
   localparam int unsigned LS = $clog2(SW);
   localparam int unsigned AW = W - LS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cyc = 1'b0, stb = 1'b0, we = 1'b0, rdy = 1'b0;
   logic [W-1:0]  addr = '0, wdat = '0, pdat = '0;
   logic [SW-1:0] sel = '0;

   logic          stall, ack;
   logic [W-1:0]  rdat, pwdat;
   logic [1:0]    op;
   logic [AW-1:0] paddr;
   logic [SW-1:0] psel;

   wb4_to_pi1 #(.ARCHBITSZ(W)) dut (
      .wb4_clk_i  (clk),
      .wb4_rst_ni (rst_n),
      .wb4_cyc_i  (cyc),
      .wb4_stb_i  (stb),
      .wb4_we_i   (we),
      .wb4_addr_i (addr),
      .wb4_data_i (wdat),
      .wb4_sel_i  (sel),
      .wb4_stall_o(stall),
      .wb4_ack_o  (ack),
      .wb4_data_o (rdat),
      .pi1_op_o   (op),
      .pi1_addr_o (paddr),
      .pi1_data_o (pwdat),
      .pi1_data_i (pdat),
      .pi1_sel_o  (psel),
      .pi1_rdy_i  (rdy)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, cyc_cnt = 0, n_ack = 0, n_cons = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Model: one outstanding transaction, tracked by whether PI1 has consumed it yet.
   typedef struct packed {
      logic          have;
      logic          cons;
      logic          abort;
      logic          ack;
      logic          we;
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
      logic [SW-1:0] sel;
      logic [W-1:0]  rdata;
   } mdl_t;

   mdl_t mdl = '0;

   function automatic mdl_t step(input mdl_t m, input logic c, input logic s, input logic w,
                                 input logic [W-1:0] a, input logic [W-1:0] d,
                                 input logic [SW-1:0] bs, input logic r, input logic [W-1:0] pd);
      mdl_t n = m;
      n.ack = 1'b0;
      if (!m.have) begin
         if (c && s) begin
            if (w && bs == '0) begin
               n.ack   = 1'b1;
               n.rdata = '0;
            end else begin
               n.have  = 1'b1;
               n.cons  = 1'b0;
               n.abort = 1'b0;
               n.we    = w;
               n.addr  = AW'(a >> LS);
               n.data  = d;
               n.sel   = bs;
            end
         end
      end else if (!m.cons) begin
         if (r) begin
            n.cons  = 1'b1;
            n.abort = !c;
         end else if (!c) begin
            n.have = 1'b0;
         end
      end else begin
         n.abort = m.abort | !c;
         if (r) begin
            n.have = 1'b0;
            if (!n.abort) begin
               n.ack   = 1'b1;
               n.rdata = m.we ? '0 : pd;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [1:0] exp_op(input mdl_t m);
      if (m.have && !m.cons) return m.we ? 2'b01 : 2'b10;
      return 2'b00;
   endfunction

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl <= '0;
      end else begin
         mdl <= step(mdl, cyc, stb, we, addr, wdat, sel, rdy, pdat);
         if (op != 2'b00 && rdy) n_cons <= n_cons + 1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         chk("op", 64'(op), 64'(exp_op(mdl)));
         chk("stall", 64'(stall), 64'(mdl.have));
         chk("ack", 64'(ack), 64'(mdl.ack));
         chk("rdata", 64'(rdat), 64'(mdl.rdata));
         if (exp_op(mdl) != 2'b00) begin
            chk("pi1_addr", 64'(paddr), 64'(mdl.addr));
            chk("pi1_data", 64'(pwdat), 64'(mdl.data));
            chk("pi1_sel", 64'(psel), 64'(mdl.sel));
         end
         if (ack) n_ack <= n_ack + 1;
      end
   end

   task automatic put(input logic w, input logic [W-1:0] a, input logic [W-1:0] d,
                      input logic [SW-1:0] s);
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
   endtask

   task automatic idle_bus();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
   endtask

   task automatic wait_ack(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (ack) begin
            at = cyc_cnt;
            break;
         end
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_op"}, 64'(op), 64'd0);
      chk({nm, "_addr"}, 64'(paddr), 64'd0);
      chk({nm, "_wdata"}, 64'(pwdat), 64'd0);
      chk({nm, "_sel"}, 64'(psel), 64'd0);
      chk({nm, "_ack"}, 64'(ack), 64'd0);
      chk({nm, "_rdata"}, 64'(rdat), 64'd0);
      chk({nm, "_stall"}, 64'(stall), 64'd0);
   endtask

   initial begin
      int acc, at, acks0, cons0, na, ni;
      int acc_t[4];
      int ack_t[4];
      bit took;

      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      chk_on = 1'b1;
      @(negedge clk);

      // Read, zero wait states.
      rdy = 1'b1; pdat = 32'hDEAD_BEEF;
      put(1'b0, 32'h0000_1008, '0, 4'hF);
      @(negedge clk); acc = cyc_cnt - 1; stb = 1'b0;
      chk("rd_op", 64'(op), 64'd2);
      chk("rd_addr", 64'(paddr), 64'h402);
      @(negedge clk);
      chk("rd_op_once", 64'(op), 64'd0);
      wait_ack(10, at);
      chk("rd_latency", 64'(at - acc), 64'd3);
      chk("rd_data", 64'(rdat), 64'hDEAD_BEEF);
      idle_bus();

      // Write, zero wait states.
      @(negedge clk);
      put(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011);
      @(negedge clk); acc = cyc_cnt - 1; stb = 1'b0;
      chk("wr_op", 64'(op), 64'd1);
      chk("wr_addr", 64'(paddr), 64'h8);
      chk("wr_sel", 64'(psel), 64'h3);
      chk("wr_wdata", 64'(pwdat), 64'h1234_5678);
      wait_ack(10, at);
      chk("wr_latency", 64'(at - acc), 64'd3);
      chk("wr_rdata", 64'(rdat), 64'd0);
      idle_bus();

      // Slave wait states: 2 low-rdy cycles in REQ, 3 in RESP.
      @(negedge clk);
      rdy = 1'b0; pdat = 32'hCAFE_F00D;
      put(1'b0, 32'h0000_0040, '0, 4'hF);
      @(negedge clk); acc = cyc_cnt - 1; stb = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         chk("ws_stall", 64'(stall), 64'd1);
         if (k <= 3) begin
            chk("ws_op_held", 64'(op), 64'd2);
            chk("ws_addr_held", 64'(paddr), 64'h10);
         end
         rdy = (k == 3 || k == 7);
         @(negedge clk);
      end
      chk("ws_ack", 64'(ack), 64'd1);
      chk("ws_latency", 64'(cyc_cnt - acc), 64'd8);
      chk("ws_stall_free", 64'(stall), 64'd0);
      chk("ws_data", 64'(rdat), 64'hCAFE_F00D);
      idle_bus();

      // sel==0 write completes locally; next request accepted in its ack cycle.
      @(negedge clk);
      rdy = 1'b1; pdat = 32'h0BAD_CAFE;
      put(1'b1, 32'h0000_0030, 32'h55, '0);
      @(negedge clk);
      chk("sel0_ack", 64'(ack), 64'd1);
      chk("sel0_op", 64'(op), 64'd0);
      chk("sel0_rdata", 64'(rdat), 64'd0);
      put(1'b0, 32'h0000_0044, '0, 4'hF);
      @(negedge clk); acc = cyc_cnt - 1; stb = 1'b0;
      chk("sel0_next_ack", 64'(ack), 64'd0);
      chk("sel0_next_op", 64'(op), 64'd2);
      chk("sel0_next_addr", 64'(paddr), 64'h11);
      wait_ack(10, at);
      chk("sel0_next_lat", 64'(at - acc), 64'd3);
      chk("sel0_next_data", 64'(rdat), 64'h0BAD_CAFE);
      idle_bus();

      // Pipelined burst W,R,W,R with stb held.
      @(negedge clk);
      rdy = 1'b1; acks0 = n_ack; cons0 = n_cons; na = 0; ni = 0;
      put(1'b1, 32'h0000_0100, 32'hB0B0_0000, 4'hF);
      for (int t = 0; t < 40 && na < 4; t++) begin
         took = (ni < 4) && !stall;
         @(negedge clk);
         pdat = 32'h5A5A_0000 + 32'(cyc_cnt);
         if (ack) begin
            ack_t[na] = cyc_cnt;
            na++;
         end
         if (took) begin
            acc_t[ni] = cyc_cnt - 1;
            ni++;
            if (ni < 4) put(ni % 2 == 0, 32'h0000_0100 + 32'(4 * ni), 32'hB0B0_0000 + 32'(ni), 4'hF);
            else stb = 1'b0;
         end
      end
      idle_bus();
      chk("burst_acks", 64'(na), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("burst_latency", 64'(ack_t[i] - acc_t[i]), 64'd3);
         if (i > 0) chk("burst_spacing", 64'(ack_t[i] - ack_t[i-1]), 64'd3);
      end
      @(negedge clk);
      chk("burst_pi1_ops", 64'(n_cons - cons0), 64'd4);
      chk("burst_ack_count", 64'(n_ack - acks0), 64'd4);

      // Abort in REQ with rdy low.
      rdy = 1'b0;
      put(1'b0, 32'h0000_0200, '0, 4'hF);
      @(negedge clk);
      chk("abreq_op", 64'(op), 64'd2);
      acks0 = n_ack;
      idle_bus();
      @(negedge clk);
      chk("abreq_op_drop", 64'(op), 64'd0);
      chk("abreq_stall", 64'(stall), 64'd0);
      repeat (3) @(negedge clk);
      chk("abreq_no_ack", 64'(n_ack - acks0), 64'd0);

      // Abort in RESP: response still drained before returning to IDLE.
      rdy = 1'b1;
      put(1'b1, 32'h0000_0300, 32'h77, 4'hF);
      @(negedge clk); stb = 1'b0;
      @(negedge clk);
      chk("abresp_in_resp", 64'(stall), 64'd1);
      acks0 = n_ack;
      cyc = 1'b0; rdy = 1'b0;
      @(negedge clk);
      chk("abresp_wait1", 64'(stall), 64'd1);
      @(negedge clk);
      chk("abresp_wait2", 64'(stall), 64'd1);
      rdy = 1'b1;
      @(negedge clk);
      chk("abresp_idle", 64'(stall), 64'd0);
      repeat (2) @(negedge clk);
      chk("abresp_no_ack", 64'(n_ack - acks0), 64'd0);

      // Asynchronous reset while in RESP.
      rdy = 1'b1; pdat = 32'h1111_2222;
      put(1'b0, 32'h0000_0400, '0, 4'hF);
      @(negedge clk); stb = 1'b0;
      @(negedge clk);
      chk("rst_in_resp", 64'(stall), 64'd1);
      rdy = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      @(negedge clk);
      idle_bus(); rdy = 1'b1;
      rst_n = 1'b1;
      acks0 = n_ack;
      repeat (4) @(negedge clk);
      chk("rst_no_ack", 64'(n_ack - acks0), 64'd0);
      chk("rst_rdata", 64'(rdat), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb4_to_pi1.md
# wb4_to_pi1

Bridge presenting a Wishbone B4 pipelined slave port and driving a single-master PI1 bus as initiator. Upstream Wishbone masters (soft cores, DMA, debug bridges) use it to reach PI1 peripherals and memory. One transaction is outstanding at a time, with registered PI1 request and Wishbone response paths. Single clock domain; no clock crossing.

## Interface
- ARCHBITSZ, 32, data width in bits. Legal values: 16, 32, 64, 128, 256.
- ADDRBITSZ (localparam), ARCHBITSZ-clog2(ARCHBITSZ/8), PI1 word-address width.

- wb4_clk_i  in  1  clock; all logic on its rising edge.
- wb4_rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- wb4_cyc_i  in  1  Wishbone cycle valid.
- wb4_stb_i  in  1  Wishbone strobe.
- wb4_we_i  in  1  1=write, 0=read.
- wb4_addr_i  in  ARCHBITSZ  byte address.
- wb4_data_i  in  ARCHBITSZ  write data.
- wb4_sel_i  in  ARCHBITSZ/8  byte enables.
- wb4_stall_o  out  1  request not accepted this cycle.
- wb4_ack_o  out  1  one-cycle completion pulse.
- wb4_data_o  out  ARCHBITSZ  read data, valid with wb4_ack_o.
- pi1_op_o  out  2  00 NOOP, 01 WR, 10 RD. 11 (RW) is never issued.
- pi1_addr_o  out  ADDRBITSZ  word address.
- pi1_data_o  out  ARCHBITSZ  write data.
- pi1_data_i  in  ARCHBITSZ  read data from the slave.
- pi1_sel_o  out  ARCHBITSZ/8  byte enables.
- pi1_rdy_i  in  1  slave ready.

## Operation
- PI1 rules:
  - An op presented while pi1_rdy_i=1 at a clock edge is consumed at that edge.
  - Its response (read data, or write completion) is the next edge at which pi1_rdy_i=1.
  - The master holds op, addr, data and sel stable until the op is consumed.
- Request acceptance: a Wishbone request is accepted at an edge where cyc_i & stb_i & !stall_o.
- wb4_stall_o = (state != IDLE), combinational from the state register.
- Address mapping: pi1_addr_o = wb4_addr_i[ARCHBITSZ-1 : clog2(ARCHBITSZ/8)]. Low address bits are ignored; sel carries the byte lanes.
- States:
  - IDLE: pi1_op_o=NOOP.
    - Write accepted with sel==0: set wb4_ack_o next cycle, stay IDLE, no PI1 op issued.
    - Any other accepted request: latch we, addr, data, sel; go REQ.
  - REQ: drive pi1_op_o = we ? WR : RD, with the latched addr/data/sel.
    - pi1_rdy_i=1: op consumed; go RESP; pi1_op_o returns to NOOP.
    - Else if cyc_i=0: abort; go IDLE; op withdrawn; no ack.
  - RESP: pi1_op_o=NOOP.
    - pi1_rdy_i=1: go IDLE, and pulse wb4_ack_o for one cycle unless the request is marked aborted.
    - Read: capture wb4_data_o <= pi1_data_i. Write: wb4_data_o <= 0.
    - If cyc_i drops while in RESP: set the aborted flag and keep waiting for pi1_rdy_i. The PI1 response is always drained.
- Aborted flag is cleared on entry to IDLE.
- wb4_data_o holds its value between acks. It is only updated at an ack edge.
- Reads with sel==0 are issued normally (pi1_sel_o=0).

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; pi1_op_o=00; pi1_addr_o, pi1_data_o, pi1_sel_o = 0; wb4_ack_o=0; wb4_data_o=0; aborted=0. wb4_stall_o=0 follows from IDLE.
- Reset mid-transaction: the in-flight op is dropped and no ack is produced.
- Minimum latency, with pi1_rdy_i held at 1: accept at edge E0, REQ during cycle 1, RESP during cycle 2, wb4_ack_o high during cycle 3. Accept to ack is 3 cycles.
- Each low-rdy cycle in REQ or RESP adds one cycle of latency.
- Back-to-back: in the wb4_ack_o cycle the state is already IDLE and stall_o=0, so the next request can be accepted. Peak throughput is 1 transaction per 3 cycles.
- sel==0 write: ack in the cycle after acceptance. A second request may be accepted in that same ack cycle.
- Simultaneous events in REQ: if pi1_rdy_i=1 and cyc_i=0 in the same cycle, the op is consumed. Go RESP with aborted=1.
- wb4_ack_o is never high for two consecutive cycles belonging to one request.

## Test plan
- Read: ARCHBITSZ=32, rdy tied 1, read addr 0x0000_1008 with sel 4'b1111.
  - Required: pi1_op_o=10 with pi1_addr_o=0x402 for exactly one cycle.
  - Required: ack 3 cycles after accept, with wb4_data_o equal to the pi1_data_i value 0xDEAD_BEEF.
- Write: write 0x1234_5678 to 0x20 with sel 4'b0011.
  - Required: pi1_op_o=01, pi1_addr_o=0x8, pi1_sel_o=0011, pi1_data_o=0x1234_5678.
  - Required: ack with wb4_data_o=0.
- Slave wait states: hold rdy=0 for 2 cycles in REQ, then 3 cycles in RESP.
  - Required: op held stable throughout REQ; ack 8 cycles after accept; stall_o=1 from accept until the ack cycle.
- Pipelined burst: 4 requests (alternating read and write) streamed with stb held.
  - Required: exactly 4 acks, in order, spaced 3 cycles apart.
  - Required: no request lost or duplicated on PI1.
- Aborts:
  - cyc_i dropped in REQ with rdy=0: op returns to NOOP next cycle; no ack.
  - cyc_i dropped in RESP: no ack; bridge returns to IDLE only after rdy=1.
- Edge cases:
  - sel==0 write: ack next cycle; pi1_op_o stays 00.
  - wb4_rst_ni asserted in RESP: all outputs 0 immediately, without waiting for a clock edge.
